// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: state encoding, opcodes,
// ALU function codes and the instruction-word layout.
package micro_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Instruction word: opcode [9:6], operand [5:0]
  localparam int INSTR_W   = 10;
  localparam int OPCODE_W  = 4;
  localparam int TARGET_W  = 6;
  localparam int OPERAND_W = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_LDA  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_NAND = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_JC   = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  // ALU function used by an accumulator-writing opcode; pass-A otherwise
  function automatic logic [2:0] alu_code(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LDA:  return ALU_PASS_B;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_NAND: return ALU_NAND;
      default: return ALU_PASS_A;
    endcase
  endfunction

  // True for opcodes that load the accumulator from the ALU
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/micro_sequencer_seq_pc.sv
// Program counter for the micro-sequencer: clear, load and increment.
// Clear wins over load, load wins over increment; increment wraps at 2^ADDR_W.
module seq_pc #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // PC register with asynchronous reset and prioritised update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Two-cycle micro-sequencer: FETCH latches the instruction and bumps the PC,
// EXEC decodes it into ALU/bus enables, conditional jumps or HALT.
// All control outputs are decoded combinationally from state and IR, so an
// asynchronous reset silences them immediately.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [9:0]        prog_data,
  input  logic              c_flag,
  input  logic              ze_flag,
  output logic [2:0]        alu_f,
  output logic              en_db,
  output logic              en_r,
  output logic              en_ff,
  output logic [4:0]        operand,
  output logic              busy,
  output logic              halted,
  output logic              out_strobe
);

  state_t                state;
  state_t                state_next;
  logic [INSTR_W-1:0]    ir;
  logic [OPCODE_W-1:0]   opcode;
  logic [TARGET_W-1:0]   target;
  logic                  zf;
  logic                  cf;
  logic                  pc_clear;
  logic                  pc_inc;
  logic                  pc_load;
  logic                  flags_clear;
  logic                  flags_load;
  logic [ADDR_W-1:0]     pc;

  assign opcode    = ir[9:6];
  assign target    = ir[5:0];
  assign prog_addr = pc;

  seq_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .clear    (pc_clear),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (ADDR_W'(target)),
    .pc       (pc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register, captured from the ROM during FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (state == ST_FETCH) begin
      ir <= prog_data;
    end
  end

  // Latched ALU flags: cleared on (re)start, updated by accumulator ops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if (flags_clear) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if (flags_load) begin
      zf <= ze_flag;
      cf <= c_flag;
    end
  end

  // Next-state, PC control and instruction decode
  always_comb begin
    state_next  = state;
    pc_clear    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    flags_clear = 1'b0;
    flags_load  = 1'b0;
    alu_f       = ALU_PASS_A;
    en_db       = 1'b0;
    en_r        = 1'b0;
    en_ff       = 1'b0;
    operand     = '0;
    out_strobe  = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;

    case (state)
      ST_IDLE, ST_HALTED: begin
        halted = (state == ST_HALTED);
        if (start) begin
          state_next  = ST_FETCH;
          pc_clear    = 1'b1;
          flags_clear = 1'b1;
        end
      end

      ST_FETCH: begin
        busy       = 1'b1;
        pc_inc     = 1'b1;
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        busy       = 1'b1;
        state_next = ST_FETCH;
        if (is_alu_op(opcode)) begin
          alu_f      = alu_code(opcode);
          en_db      = 1'b1;
          en_ff      = 1'b1;
          operand    = ir[OPERAND_W-1:0];
          flags_load = 1'b1;
        end else begin
          case (opcode)
            OP_OUT: begin
              en_r       = 1'b1;
              out_strobe = 1'b1;
            end
            OP_JMP:  pc_load = 1'b1;
            OP_JZ:   pc_load = zf;
            OP_JC:   pc_load = cf;
            OP_HALT: state_next = ST_HALTED;
            default: ;
          endcase
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a ROM, an 8-bit ALU and an accumulator surround
// the DUT, and an instruction-level reference model predicts every cycle.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] prog_addr;
  logic [9:0] prog_data;
  logic       c_flag;
  logic       ze_flag;
  logic [2:0] alu_f;
  logic       en_db;
  logic       en_r;
  logic       en_ff;
  logic [4:0] operand;
  logic       busy;
  logic       halted;
  logic       out_strobe;

  micro_sequencer #(.ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .c_flag     (c_flag),
    .ze_flag    (ze_flag),
    .alu_f      (alu_f),
    .en_db      (en_db),
    .en_r       (en_r),
    .en_ff      (en_ff),
    .operand    (operand),
    .busy       (busy),
    .halted     (halted),
    .out_strobe (out_strobe)
  );

  always #5 clk = ~clk;

  // Program ROM and datapath environment
  logic [9:0] rom [0:63];
  logic [7:0] acc = 8'h00;
  logic [7:0] dbus;
  logic [7:0] alu_y;
  logic [7:0] rbus;
  logic       alu_c;

  assign prog_data = rom[prog_addr];

  always_comb begin
    dbus  = en_db ? {3'b000, operand} : 8'h00;
    alu_c = 1'b0;
    alu_y = acc;
    case (alu_f)
      3'b001:  {alu_c, alu_y} = {1'b0, acc} - {1'b0, dbus};
      3'b010:  alu_y = dbus;
      3'b011:  {alu_c, alu_y} = {1'b0, acc} + {1'b0, dbus};
      3'b100:  alu_y = ~(acc & dbus);
      default: alu_y = acc;
    endcase
  end

  assign c_flag  = alu_c;
  assign ze_flag = (alu_y == 8'h00);
  assign rbus    = en_r ? alu_y : 8'h00;

  always @(posedge clk) if (en_ff) acc <= alu_y;

  // Reference model state (instruction level)
  int         m_pc;
  int         m_acc = 0;
  bit         m_zf;
  bit         m_cf;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_out;
  int         cyc;
  int         fin_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input bit exp_halted);
    chk({tag, "_ctl"}, {20'd0, en_db, en_r, en_ff, out_strobe, alu_f, operand}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, exp_halted});
  endtask

  // Accumulator effect of LDA/ADD/SUB/NAND expressed in plain arithmetic
  function automatic void m_alu(input int op, input int b);
    int r;
    r = m_acc;
    case (op)
      1: begin r = b; m_cf = 0; end
      2: begin r = m_acc + b; m_cf = (r > 255); r = r % 256; end
      3: begin m_cf = (m_acc < b); r = (m_acc - b + 256) % 256; end
      4: begin r = 255 - (m_acc & b); m_cf = 0; end
      default: ;
    endcase
    m_zf  = (r == 0);
    m_acc = r;
  endfunction

  function automatic logic [9:0] ins(input int op, input int arg);
    logic [9:0] w;
    w = {op[3:0], arg[5:0]};
    return w;
  endfunction

  task automatic clr_rom();
    for (int i = 0; i < 64; i++) rom[i] = 10'd0;
  endtask

  // Start the DUT and follow it instruction by instruction. Stops at HALT,
  // at the instruction budget (then resets), or asserts reset in the EXEC
  // cycle of instruction number rst_at.
  task automatic run_prog(input int budget, input bit noise, input int rst_at,
                          output int busy_cyc, output int final_addr);
    logic [9:0] ir;
    int         op;
    bit         alu_op;
    bit         is_out;
    logic [2:0] f;
    logic [4:0] exp_opnd;
    busy_cyc   = 0;
    final_addr = -1;
    m_pc = 0; m_zf = 0; m_cf = 0;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < budget; n++) begin
      chk("fetch_busy", {31'd0, busy}, 32'd1);
      chk("fetch_halted", {31'd0, halted}, 32'd0);
      chk("fetch_addr", {26'd0, prog_addr}, m_pc);
      chk("fetch_ctl", {20'd0, en_db, en_r, en_ff, out_strobe, alu_f, operand}, 32'd0);
      ir   = rom[m_pc];
      op   = int'(ir[9:6]);
      m_pc = (m_pc + 1) % 64;
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      busy_cyc++;
      alu_op   = (op >= 1 && op <= 4);
      is_out   = (op == 5);
      f        = (op == 1) ? 3'b010 : (op == 2) ? 3'b011 :
                 (op == 3) ? 3'b001 : (op == 4) ? 3'b100 : 3'b000;
      exp_opnd = alu_op ? ir[4:0] : 5'd0;
      chk("exec_busy", {31'd0, busy}, 32'd1);
      chk("exec_addr", {26'd0, prog_addr}, m_pc);
      chk("exec_ctl", {20'd0, en_db, en_r, en_ff, out_strobe, alu_f, operand},
          {20'd0, alu_op, is_out, alu_op, is_out, f, exp_opnd});
      if (is_out) begin
        chk("out_value", {24'd0, rbus}, m_acc);
        last_out = rbus;
      end
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        chk_idle("rst_async", 1'b0);
        chk("rst_addr", {26'd0, prog_addr}, 32'd0);
        @(posedge clk); #1;
        chk("rst_acc", {24'd0, acc}, m_acc);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (alu_op) m_alu(op, int'(ir[4:0]));
      else if (op == 6 || (op == 7 && m_zf) || (op == 8 && m_cf)) m_pc = int'(ir[5:0]);
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      busy_cyc++;
      if (op == 15) begin
        chk_idle("halt", 1'b1);
        chk("halt_addr", {26'd0, prog_addr}, m_pc);
        final_addr = int'(prog_addr);
        return;
      end
    end
    final_addr = int'(prog_addr);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    last_out = 8'h00;
    clr_rom();
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b0);
    chk("reset_addr", {26'd0, prog_addr}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("idle_hold", 1'b0);

    // LDA 5; ADD 3; OUT; HALT -> result bus 8 after 8 busy clocks
    clr_rom();
    rom[0] = ins(1, 5); rom[1] = ins(2, 3); rom[2] = ins(5, 0); rom[3] = ins(15, 0);
    run_prog(20, 1'b0, -1, cyc, fin_addr);
    chk("p1_out", {24'd0, last_out}, 32'd8);
    chk("p1_cycles", cyc, 32'd8);

    // LDA 3; SUB 3; JZ 6 -> taken, HALT at 6
    clr_rom();
    rom[0] = ins(1, 3); rom[1] = ins(3, 3); rom[2] = ins(7, 6);
    rom[3] = ins(15, 0); rom[6] = ins(15, 0);
    run_prog(20, 1'b0, -1, cyc, fin_addr);
    chk("jz_taken", fin_addr, 32'd7);
    rom[1] = ins(3, 2);
    run_prog(20, 1'b0, -1, cyc, fin_addr);
    chk("jz_not_taken", fin_addr, 32'd4);

    // PC wrap: JMP 62 at 0, JMP 63 at 62, NOP at 63 -> next fetch at 0
    clr_rom();
    rom[0] = ins(6, 62); rom[62] = ins(6, 63); rom[63] = ins(0, 0);
    run_prog(3, 1'b0, -1, cyc, fin_addr);
    chk("pc_wrap", fin_addr, 32'd0);

    // Reset during EXEC of ADD leaves the accumulator untouched
    clr_rom();
    rom[0] = ins(1, 7); rom[1] = ins(2, 4); rom[2] = ins(15, 0);
    run_prog(20, 1'b0, 1, cyc, fin_addr);
    chk("rst_acc_value", {24'd0, acc}, 32'd7);
    repeat (2) @(negedge clk);
    chk_idle("rst_stays_idle", 1'b0);

    // Start while busy is ignored; restart from HALTED clears flags
    clr_rom();
    rom[0] = ins(1, 0); rom[1] = ins(15, 0);
    run_prog(20, 1'b1, -1, cyc, fin_addr);
    rom[0] = ins(7, 5); rom[5] = ins(15, 0);
    run_prog(20, 1'b1, -1, cyc, fin_addr);
    chk("restart_flags_clear", fin_addr, 32'd2);

    // Undefined opcode 1010 behaves as NOP
    clr_rom();
    rom[0] = ins(10, 63); rom[1] = ins(15, 0);
    run_prog(20, 1'b0, -1, cyc, fin_addr);
    chk("undef_op_pc", fin_addr, 32'd2);

    // Random programs, random start noise and random mid-run resets
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 64; i++) rom[i] = 10'($urandom_range(0, 1023));
      run_prog(30, 1'b1, int'($urandom_range(0, 45)), cyc, fin_addr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
